// File: rtl/aes_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : aes_arbiter
// Description : Round-robin front end sharing one aes_core between two
//               requesters, with a bounded wait for the core's result.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_arbiter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic         clk_in,
    input  logic         rst_in,

    input  logic         req0_valid_in,
    input  logic         req0_mode_in,
    input  logic [127:0] req0_data_in,
    input  logic         req1_valid_in,
    input  logic         req1_mode_in,
    input  logic [127:0] req1_data_in,

    output logic         req0_ready_out,
    output logic [127:0] req0_result_out,
    output logic         req0_result_valid_out,
    output logic         req1_ready_out,
    output logic [127:0] req1_result_out,
    output logic         req1_result_valid_out,

    output logic         core_init_out,
    output logic         core_mode_out,
    output logic [127:0] core_data_out,
    input  logic [127:0] core_data_in,
    input  logic         core_valid_in,

    output logic         busy_out,
    output logic         timeout_out
);

    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RESPOND = 2'd3
    } state_t;

    state_t           state_q,      state_d;
    logic             last_grant_q, last_grant_d;
    logic             mode_q,       mode_d;
    logic [127:0]     data_q,       data_d;
    logic [127:0]     result0_q,    result0_d;
    logic [127:0]     result1_q,    result1_d;
    logic [CNT_W-1:0] wait_cnt_q,   wait_cnt_d;
    logic             timeout_q,    timeout_d;
    logic             pick;
    logic             wait_expired;

    // The counter holds the number of WAIT cycles already completed, so the
    // current cycle is the last permitted one when count + 1 reaches the limit.
    assign wait_expired = (int'(wait_cnt_q) + 1) >= TIMEOUT_CYCLES;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        mode_d       = mode_q;
        data_d       = data_q;
        result0_d    = result0_q;
        result1_d    = result1_q;
        wait_cnt_d   = wait_cnt_q;
        timeout_d    = timeout_q;
        pick         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req0_valid_in || req1_valid_in) begin
                    if (req0_valid_in && req1_valid_in) begin
                        pick = ~last_grant_q;
                    end else begin
                        pick = req1_valid_in;
                    end
                    last_grant_d = pick;
                    mode_d       = pick ? req1_mode_in : req0_mode_in;
                    data_d       = pick ? req1_data_in : req0_data_in;
                    state_d      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                wait_cnt_d = '0;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                if (core_valid_in) begin
                    if (last_grant_q) begin
                        result1_d = core_data_in;
                    end else begin
                        result0_d = core_data_in;
                    end
                    state_d = ST_RESPOND;
                end else if (wait_expired) begin
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end else if (wait_cnt_q != {CNT_W{1'b1}}) begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            ST_RESPOND: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            mode_q       <= 1'b0;
            data_q       <= '0;
            result0_q    <= '0;
            result1_q    <= '0;
            wait_cnt_q   <= '0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            mode_q       <= mode_d;
            data_q       <= data_d;
            result0_q    <= result0_d;
            result1_q    <= result1_d;
            wait_cnt_q   <= wait_cnt_d;
            timeout_q    <= timeout_d;
        end
    end

    assign req0_ready_out        = (state_q == ST_ISSUE)   && !last_grant_q;
    assign req1_ready_out        = (state_q == ST_ISSUE)   &&  last_grant_q;
    assign req0_result_valid_out = (state_q == ST_RESPOND) && !last_grant_q;
    assign req1_result_valid_out = (state_q == ST_RESPOND) &&  last_grant_q;
    assign req0_result_out       = result0_q;
    assign req1_result_out       = result1_q;
    assign core_init_out         = (state_q == ST_ISSUE);
    assign core_mode_out         = mode_q;
    assign core_data_out         = data_q;
    assign busy_out              = (state_q != ST_IDLE);
    assign timeout_out           = timeout_q;

endmodule
`default_nettype wire
